// File: rtl/fp_collect_pkg.sv
// Shared FP32 field layout, result-class bit positions and collector state type
// for fp_result_collector and its FIFO.
package fp_collect_pkg;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB = 30;
    localparam int EXP_LSB = 23;
    localparam int FRAC_W = 23;
    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

    localparam int CLS_ZERO = 0;
    localparam int CLS_DENORM = 1;
    localparam int CLS_INF = 2;
    localparam int CLS_NAN = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_COLLECT = 1'b1
    } collect_state_t;

    // The sign never affects the class, so only exponent and fraction are passed in.
    function automatic logic [3:0] fp_classify(input logic [SIGN_BIT-1:0] mag);
        logic [7:0] exp_f;
        logic frac_nz;
        exp_f = mag[EXP_MSB:EXP_LSB];
        frac_nz = |mag[FRAC_W-1:0];
        fp_classify = '0;
        fp_classify[CLS_ZERO] = (exp_f == 8'h00) && !frac_nz;
        fp_classify[CLS_DENORM] = (exp_f == 8'h00) && frac_nz;
        fp_classify[CLS_INF] = (exp_f == EXP_ALL_ONES) && !frac_nz;
        fp_classify[CLS_NAN] = (exp_f == EXP_ALL_ONES) && frac_nz;
    endfunction

endpackage

// File: rtl/result_fifo.sv
// Synchronous first-word-fall-through FIFO; a write into a full FIFO is only
// taken when a read happens in the same cycle, otherwise it is dropped.
module result_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 32,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [LVL_W-1:0] level
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic do_wr;
    logic do_rd;

    assign empty = (level == '0);
    assign full = (level == LVL_W'(DEPTH));
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, do_rd})
                2'b10: level <= level + 1'b1;
                2'b01: level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/fp_result_collector.sv
// Reassembles byte-serial FP32 ALU results into words and queues them for the host.
// Build option RESULT_CLASSIFY_EN stores a zero/denorm/inf/NaN class with each word.
//
// state      | meaning
// ST_IDLE    | waiting for the first byte of a frame
// ST_COLLECT | bytes 1..3 of a frame expected on consecutive cycles
module fp_result_collector
    import fp_collect_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int LVL_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       byte_in,
    input  logic             byte_valid,
    output logic [31:0]      res_data,
    output logic [3:0]       res_class,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [LVL_W-1:0] level,
    output logic             frame_err,
    output logic             ovf_err,
    input  logic             clr_err
);

    collect_state_t state;
    logic [1:0] byte_cnt;
    logic [23:0] low_bytes;
    logic [31:0] push_word;
    logic push;
    logic pop;
    logic fifo_full;
    logic fifo_empty;

    assign push = (state == ST_COLLECT) && byte_valid && (byte_cnt == 2'd3);
    assign push_word = {byte_in, low_bytes};
    assign res_valid = !fifo_empty;
    assign pop = res_valid && res_ready;

`ifdef RESULT_CLASSIFY_EN
    localparam int FIFO_W = 36;
    logic [FIFO_W-1:0] wr_data;
    logic [FIFO_W-1:0] rd_data;
    assign wr_data = {fp_classify(push_word[SIGN_BIT-1:0]), push_word};
    assign res_data = rd_data[31:0];
    assign res_class = rd_data[35:32];
`else
    localparam int FIFO_W = 32;
    logic [FIFO_W-1:0] wr_data;
    logic [FIFO_W-1:0] rd_data;
    assign wr_data = push_word;
    assign res_data = rd_data;
    assign res_class = '0;
`endif

    // Bytes shift in from the top, so after three bytes low_bytes holds {b2, b1, b0}.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            byte_cnt <= '0;
            low_bytes <= '0;
            frame_err <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            if (clr_err) begin
                frame_err <= 1'b0;
                ovf_err <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (byte_valid) begin
                        low_bytes <= {byte_in, low_bytes[23:8]};
                        byte_cnt <= 2'd1;
                        state <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (!byte_valid) begin
                        frame_err <= 1'b1;
                        byte_cnt <= '0;
                        state <= ST_IDLE;
                    end else if (push) begin
                        byte_cnt <= '0;
                        state <= ST_IDLE;
                    end else begin
                        low_bytes <= {byte_in, low_bytes[23:8]};
                        byte_cnt <= byte_cnt + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (push && fifo_full && !pop) begin
                ovf_err <= 1'b1;
            end
        end
    end

    result_fifo #(
        .DEPTH(DEPTH),
        .WIDTH(FIFO_W),
        .LVL_W(LVL_W)
    ) u_fifo (
        .clk(clk),
        .rst(rst),
        .wr_en(push),
        .wr_data(wr_data),
        .rd_en(pop),
        .rd_data(rd_data),
        .full(fifo_full),
        .empty(fifo_empty),
        .level(level)
    );

endmodule

// File: tb/tb_fp_result_collector.sv
// Bench for fp_result_collector: directed scenarios plus randomized frames, all
// compared every cycle against a queue-based model of frames, FIFO and error flags.
module tb_fp_result_collector;

    localparam int DEPTH = 2;
    localparam int LVL_W = $clog2(DEPTH + 1);
`ifdef RESULT_CLASSIFY_EN
    localparam bit CLS_EN = 1'b1;
`else
    localparam bit CLS_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [7:0] byte_in = '0;
    logic byte_valid = 1'b0;
    logic [31:0] res_data;
    logic [3:0] res_class;
    logic res_valid;
    logic res_ready = 1'b0;
    logic [LVL_W-1:0] level;
    logic frame_err;
    logic ovf_err;
    logic clr_err = 1'b0;

    int checks = 0;
    int failures = 0;

    logic [31:0] m_q[$];
    logic [7:0] m_bytes[$];
    logic m_ferr = 1'b0;
    logic m_oerr = 1'b0;

    always #5 clk = ~clk;

    fp_result_collector #(.DEPTH(DEPTH), .LVL_W(LVL_W)) dut (
        .clk(clk),
        .rst(rst),
        .byte_in(byte_in),
        .byte_valid(byte_valid),
        .res_data(res_data),
        .res_class(res_class),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .level(level),
        .frame_err(frame_err),
        .ovf_err(ovf_err),
        .clr_err(clr_err)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] exp_class(input logic [31:0] w);
        int unsigned e;
        int unsigned f;
        logic [3:0] c;
        e = w[30:23];
        f = w[22:0];
        if (e == 0) c = (f == 0) ? 4'b0001 : 4'b0010;
        else if (e == 255) c = (f == 0) ? 4'b0100 : 4'b1000;
        else c = 4'b0000;
        return CLS_EN ? c : 4'b0000;
    endfunction

    // Frames are whole runs of byte_valid; any run that ends before 4 bytes is short.
    task automatic model_edge();
        bit popping;
        bit new_word;
        logic [31:0] w;
        if (rst) begin
            m_q.delete();
            m_bytes.delete();
            m_ferr = 1'b0;
            m_oerr = 1'b0;
            return;
        end
        popping = res_ready && (m_q.size() > 0);
        new_word = 1'b0;
        w = '0;
        if (clr_err) begin
            m_ferr = 1'b0;
            m_oerr = 1'b0;
        end
        if (byte_valid) begin
            m_bytes.push_back(byte_in);
            if (m_bytes.size() == 4) begin
                w = {m_bytes[3], m_bytes[2], m_bytes[1], m_bytes[0]};
                new_word = 1'b1;
                m_bytes.delete();
            end
        end else if (m_bytes.size() > 0) begin
            m_ferr = 1'b1;
            m_bytes.delete();
        end
        if (popping) void'(m_q.pop_front());
        if (new_word) begin
            if (m_q.size() < DEPTH) m_q.push_back(w);
            else m_oerr = 1'b1;
        end
    endtask

    task automatic compare_all();
        logic [31:0] head;
        head = (m_q.size() > 0) ? m_q[0] : 32'h0;
        chk("res_valid", 32'(res_valid), 32'(m_q.size() > 0));
        chk("level", 32'(level), 32'(m_q.size()));
        chk("res_data", res_data, head);
        chk("res_class", 32'(res_class), (m_q.size() > 0) ? 32'(exp_class(head)) : 32'h0);
        chk("frame_err", 32'(frame_err), 32'(m_ferr));
        chk("ovf_err", 32'(ovf_err), 32'(m_oerr));
    endtask

    task automatic cycle(input logic bv, input logic [7:0] b, input logic rdy,
                         input logic clr, input logic r);
        byte_valid = bv;
        byte_in = b;
        res_ready = rdy;
        clr_err = clr;
        rst = r;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic send_frame(input logic [31:0] w, input logic rdy);
        for (int i = 0; i < 4; i++) cycle(1'b1, w[8*i +: 8], rdy, 1'b0, 1'b0);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, rdy, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0] cls_words [4];
        logic [3:0] cls_exp [4];
        cls_words = '{32'h7FC00000, 32'h7F800000, 32'h00000001, 32'h80000000};
        cls_exp = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

        for (int i = 0; i < 3; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("reset_valid", 32'(res_valid), 32'h0);
        chk("reset_level", 32'(level), 32'h0);

        send_frame(32'h3F800000, 1'b1);
        chk("normal_data", res_data, 32'h3F800000);
        chk("normal_class", 32'(res_class), 32'h0);
        idle(1, 1'b1);
        chk("normal_drain", 32'(res_valid), 32'h0);

        for (int i = 0; i < 4; i++) begin
            send_frame(cls_words[i], 1'b0);
            chk("class_word", 32'(res_class), CLS_EN ? 32'(cls_exp[i]) : 32'h0);
            idle(1, 1'b1);
        end

        send_frame(32'h11111111, 1'b0);
        send_frame(32'h22222222, 1'b0);
        send_frame(32'h33333333, 1'b0);
        chk("bp_level", 32'(level), 32'd2);
        chk("bp_ovf", 32'(ovf_err), 32'h1);
        chk("bp_head1", res_data, 32'h11111111);
        idle(1, 1'b1);
        chk("bp_head2", res_data, 32'h22222222);
        idle(1, 1'b1);
        chk("bp_empty", 32'(res_valid), 32'h0);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("bp_clr", 32'(ovf_err), 32'h0);

        cycle(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        idle(1, 1'b0);
        chk("short_ferr", 32'(frame_err), 32'h1);
        chk("short_level", 32'(level), 32'h0);
        send_frame(32'hC0490FDB, 1'b0);
        chk("short_next", res_data, 32'hC0490FDB);
        cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("short_clr", 32'(frame_err), 32'h0);

        for (int i = 1; i <= 8; i++) cycle(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        chk("b2b_level", 32'(level), 32'd2);
        chk("b2b_first", res_data, 32'h04030201);
        idle(1, 1'b1);
        chk("b2b_second", res_data, 32'h08070605);
        idle(1, 1'b1);

        cycle(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 8'h34, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        chk("rst_mid_level", 32'(level), 32'h0);
        chk("rst_mid_valid", 32'(res_valid), 32'h0);
        send_frame(32'hDEADBEEF, 1'b0);
        chk("rst_mid_next", res_data, 32'hDEADBEEF);
        idle(2, 1'b1);

        for (int n = 0; n < 800; n++) begin
            int len;
            int gap;
            case ($urandom_range(0, 5))
                0: len = int'($urandom_range(1, 3));
                1: len = 8;
                default: len = 4;
            endcase
            gap = int'($urandom_range(1, 3));
            for (int i = 0; i < len; i++)
                cycle(1'b1, 8'($urandom), ($urandom % 3) != 0,
                      ($urandom % 25) == 0, ($urandom % 400) == 0);
            for (int i = 0; i < gap; i++)
                cycle(1'b0, 8'($urandom), ($urandom % 3) != 0,
                      ($urandom % 25) == 0, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
